// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the CPU/DMA memory arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   localparam int MAX_BURST_DEF = 4;
   localparam int CNT_W_DEF     = 16;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
// Counts one per enabled cycle; there is no backpressure.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between CPU and DMA; a granted beat completes in its grant cycle.
// Masters hold req until granted; DMA bursts are cut after MAX_BURST beats while the CPU waits.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_adr,
   input  logic [31:0]      cpu_wdata,
   output logic             cpu_gnt,
   output logic [31:0]      cpu_rdata,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [31:0]      dma_adr,
   input  logic [31:0]      dma_wdata,
   output logic             dma_gnt,
   output logic [31:0]      dma_rdata,
   output logic [31:0]      mem_adr,
   output logic [31:0]      mem_wdata,
   output logic             mem_we,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] cpu_wait_cnt
);
   localparam logic [7:0] BCNT_MAX = 8'(MAX_BURST - 1);

   owner_t     state;
   owner_t     state_nxt;
   logic       last;
   logic [7:0] bcnt;
   logic [7:0] bcnt_nxt;
   logic       keep_dma;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= OWN_IDLE;
         last  <= 1'b1;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         bcnt  <= bcnt_nxt;
         if (cpu_gnt) begin
            last <= 1'b0;
         end else if (dma_gnt) begin
            last <= 1'b1;
         end
      end
   end

   // bcnt only survives while DMA is retained; every other path restarts the burst at 0.
   always_comb begin
      state_nxt = state;
      bcnt_nxt  = '0;
      keep_dma  = dma_req && (!cpu_req || (bcnt < BCNT_MAX));
      case (state)
         OWN_IDLE: begin
            if (cpu_req && dma_req) state_nxt = last ? OWN_CPU : OWN_DMA;
            else if (cpu_req)       state_nxt = OWN_CPU;
            else if (dma_req)       state_nxt = OWN_DMA;
            else                    state_nxt = OWN_IDLE;
         end
         OWN_CPU: begin
            if (dma_req)      state_nxt = OWN_DMA;
            else if (cpu_req) state_nxt = OWN_CPU;
            else              state_nxt = OWN_IDLE;
         end
         OWN_DMA: begin
            if (keep_dma) begin
               state_nxt = OWN_DMA;
               bcnt_nxt  = (bcnt < BCNT_MAX) ? bcnt + 8'd1 : bcnt;
            end else if (cpu_req) begin
               state_nxt = OWN_CPU;
            end else if (dma_req) begin
               state_nxt = OWN_DMA;
            end else begin
               state_nxt = OWN_IDLE;
            end
         end
         default: state_nxt = OWN_IDLE;
      endcase
   end

   always_comb begin
      cpu_gnt   = (state == OWN_CPU) && cpu_req;
      dma_gnt   = (state == OWN_DMA) && dma_req;
      mem_adr   = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (cpu_gnt) begin
         mem_adr   = cpu_adr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we && !reset;
      end else if (dma_gnt) begin
         mem_adr   = dma_adr;
         mem_wdata = dma_wdata;
         mem_we    = dma_we && !reset;
      end
   end

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   sat_counter #(.W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (cpu_req && !cpu_gnt),
      .cnt   (cpu_wait_cnt)
   );
endmodule
